cram_wr_arb: RTL and testbench

Write-side controller for the 256×16 colour RAM (CRAM) read by the video output stage. It merges three write sources onto the single CRAM write port: CPU byte writes, assembled into words; DMA word writes with a request/acknowledge handshake; and a built-in fill sequencer that initialises all 256 entries. It can also defer all commits to blanking to avoid mid-line palette tearing. It sits between the port/DMA logic and the `cram_addr_in`/`cram_data_in`/`cram_we` inputs of the video output block.

---
 rtl/cram_arb_pkg.sv | 19 +
 rtl/cram_fill_seq.sv | 54 +++++
 rtl/cram_wr_arb.sv | 116 +++++++++++
 tb/tb_cram_wr_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cram_arb_pkg.sv
// Shared widths and enums for the CRAM write-side arbiter.
package cram_arb_pkg;

  localparam int unsigned CRAM_AW = 8;
  localparam int unsigned CRAM_DW = 16;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2,
    GNT_FILL = 2'd3
  } gnt_e;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cram_fill_seq.sv
// Fill sequencer: walks entries 0..FILL_LAST writing one captured word,
// advancing only when the arbiter grants it.
module cram_fill_seq
  import cram_arb_pkg::*;
#(
  parameter logic [CRAM_AW-1:0] FILL_LAST = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CRAM_DW-1:0] fill_data,
  input  logic               gnt,
  output logic               req,
  output logic [CRAM_AW-1:0] addr,
  output logic [CRAM_DW-1:0] data,
  output logic               busy
);

  fill_state_e        state;
  logic [CRAM_AW-1:0] fill_ptr;
  logic [CRAM_DW-1:0] fill_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL_IDLE;
      fill_ptr  <= '0;
      fill_word <= '0;
    end else begin
      case (state)
        FILL_IDLE: begin
          if (start) begin
            state     <= FILL_RUN;
            fill_ptr  <= '0;
            fill_word <= fill_data;
          end
        end
        FILL_RUN: begin
          // start is ignored here; a stalled fill resumes at the same pointer
          if (gnt) begin
            fill_ptr <= CRAM_AW'(fill_ptr + 1'b1);
            if (fill_ptr == FILL_LAST) state <= FILL_IDLE;
          end
        end
        default: state <= FILL_IDLE;
      endcase
    end
  end

  assign req  = (state == FILL_RUN);
  assign busy = (state == FILL_RUN);
  assign addr = fill_ptr;
  assign data = fill_word;

endmodule

// File: rtl/cram_wr_arb.sv
// CRAM write-port arbiter: CPU byte assembly, DMA handshake and fill
// sequencer merged by fixed priority onto one registered write port.
module cram_wr_arb
  import cram_arb_pkg::*;
#(
  parameter logic [CRAM_AW-1:0] FILL_LAST = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blank,
  input  logic               wr_blank_only,
  input  logic               cpu_wr,
  input  logic [8:0]         cpu_addr,
  input  logic [7:0]         cpu_data,
  input  logic               dma_req,
  input  logic [CRAM_AW-1:0] dma_addr,
  input  logic [CRAM_DW-1:0] dma_data,
  output logic               dma_ack,
  input  logic               fill_start,
  input  logic [CRAM_DW-1:0] fill_data,
  output logic               fill_busy,
  output logic               cpu_ovf,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_data,
  output logic               cram_we
);

  logic [7:0]         lo_byte;
  logic               cpu_pend;
  logic [CRAM_AW-1:0] cpu_slot_addr;
  logic [CRAM_DW-1:0] cpu_slot_data;

  logic               fill_req;
  logic [CRAM_AW-1:0] fill_addr;
  logic [CRAM_DW-1:0] fill_word;

  logic               en;
  gnt_e               gnt;

  cram_fill_seq #(
    .FILL_LAST (FILL_LAST)
  ) u_fill (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (fill_start),
    .fill_data (fill_data),
    .gnt       (gnt == GNT_FILL),
    .req       (fill_req),
    .addr      (fill_addr),
    .data      (fill_word),
    .busy      (fill_busy)
  );

  assign en = !wr_blank_only || blank;

  // Fixed priority CPU > DMA > fill, at most one grant per cycle
  always_comb begin
    gnt = GNT_NONE;
    if (en) begin
      if (cpu_pend)      gnt = GNT_CPU;
      else if (dma_req)  gnt = GNT_DMA;
      else if (fill_req) gnt = GNT_FILL;
    end
  end

  // CPU byte assembly; a load coinciding with the slot's grant is not an overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_byte       <= '0;
      cpu_pend      <= 1'b0;
      cpu_slot_addr <= '0;
      cpu_slot_data <= '0;
      cpu_ovf       <= 1'b0;
    end else begin
      if (cpu_wr && !cpu_addr[0]) begin
        lo_byte <= cpu_data;
      end
      if (cpu_wr && cpu_addr[0]) begin
        cpu_slot_addr <= cpu_addr[8:1];
        cpu_slot_data <= {cpu_data, lo_byte};
        cpu_pend      <= 1'b1;
        if (cpu_pend && gnt != GNT_CPU) cpu_ovf <= 1'b1;
      end else if (gnt == GNT_CPU) begin
        cpu_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cram_we   <= 1'b0;
      dma_ack   <= 1'b0;
      cram_addr <= '0;
      cram_data <= '0;
    end else begin
      cram_we <= (gnt != GNT_NONE);
      dma_ack <= (gnt == GNT_DMA);
      case (gnt)
        GNT_CPU: begin
          cram_addr <= cpu_slot_addr;
          cram_data <= cpu_slot_data;
        end
        GNT_DMA: begin
          cram_addr <= dma_addr;
          cram_data <= dma_data;
        end
        GNT_FILL: begin
          cram_addr <= fill_addr;
          cram_data <= fill_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_wr_arb.sv
// Directed bench for cram_wr_arb; inputs driven and outputs sampled on negedge.
module tb_cram_wr_arb;

  logic        clk;
  logic        rst_n;
  logic        blank;
  logic        wr_blank_only;
  logic        cpu_wr;
  logic [8:0]  cpu_addr;
  logic [7:0]  cpu_data;
  logic        dma_req;
  logic [7:0]  dma_addr;
  logic [15:0] dma_data;
  logic        dma_ack;
  logic        fill_start;
  logic [15:0] fill_data;
  logic        fill_busy;
  logic        cpu_ovf;
  logic [7:0]  cram_addr;
  logic [15:0] cram_data;
  logic        cram_we;

  int n_checks = 0;
  int n_fail   = 0;

  cram_wr_arb #(.FILL_LAST(8'hFF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .blank         (blank),
    .wr_blank_only (wr_blank_only),
    .cpu_wr        (cpu_wr),
    .cpu_addr      (cpu_addr),
    .cpu_data      (cpu_data),
    .dma_req       (dma_req),
    .dma_addr      (dma_addr),
    .dma_data      (dma_data),
    .dma_ack       (dma_ack),
    .fill_start    (fill_start),
    .fill_data     (fill_data),
    .fill_busy     (fill_busy),
    .cpu_ovf       (cpu_ovf),
    .cram_addr     (cram_addr),
    .cram_data     (cram_data),
    .cram_we       (cram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_byte(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".we"},   32'(cram_we),   32'h0);
    check({tag, ".ack"},  32'(dma_ack),   32'h0);
    check({tag, ".busy"}, 32'(fill_busy), 32'h0);
    check({tag, ".ovf"},  32'(cpu_ovf),   32'h0);
    check({tag, ".addr"}, 32'(cram_addr), 32'h0);
    check({tag, ".data"}, 32'(cram_data), 32'h0);
  endtask

  initial begin
    int we_cnt, ack_cnt, busy_cnt, bad_addr, bad_data, first_we, last_we;
    logic [7:0] exp_addr;
    bit found;

    rst_n = 1'b0; blank = 1'b0; wr_blank_only = 1'b0;
    cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
    dma_req = 1'b0; dma_addr = '0; dma_data = '0;
    fill_start = 1'b0; fill_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // CPU word assembly: 1234h to entry 05h
    cpu_byte(9'h00A, 8'h34);
    cpu_byte(9'h00B, 8'h12);
    @(negedge clk);
    cpu_wr = 1'b0;
    check("cpu.we_e0", 32'(cram_we), 32'h0);
    @(negedge clk);
    check("cpu.we",   32'(cram_we),   32'h1);
    check("cpu.addr", 32'(cram_addr), 32'h05);
    check("cpu.data", 32'(cram_data), 32'h1234);
    @(negedge clk);
    check("cpu.we_off",  32'(cram_we),   32'h0);
    check("cpu.hold",    32'(cram_addr), 32'h05);

    // Contention: CPU and DMA both pending while gated, then blank opens
    wr_blank_only = 1'b1;
    cpu_byte(9'h020, 8'hCD);
    cpu_byte(9'h021, 8'hAB);
    dma_req = 1'b1; dma_addr = 8'h20; dma_data = 16'h5555;
    @(negedge clk);
    cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("cont.gated", 32'(cram_we), 32'h0);
    blank = 1'b1;
    @(negedge clk);
    check("cont.cpu_we",   32'(cram_we),   32'h1);
    check("cont.cpu_addr", 32'(cram_addr), 32'h10);
    check("cont.cpu_data", 32'(cram_data), 32'hABCD);
    check("cont.cpu_ack",  32'(dma_ack),   32'h0);
    @(negedge clk);
    check("cont.dma_we",   32'(cram_we),   32'h1);
    check("cont.dma_ack",  32'(dma_ack),   32'h1);
    check("cont.dma_addr", 32'(cram_addr), 32'h20);
    check("cont.dma_data", 32'(cram_data), 32'h5555);
    dma_req = 1'b0;
    ack_cnt = 0; we_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      ack_cnt += int'(dma_ack);
      we_cnt  += int'(cram_we);
    end
    check("cont.no_reack", 32'(ack_cnt), 32'h0);
    check("cont.no_rewe",  32'(we_cnt),  32'h0);
    wr_blank_only = 1'b0; blank = 1'b0;

    // Fill all 256 entries with 7FFFh, with an ignored restart mid-run
    @(negedge clk);
    fill_start = 1'b1; fill_data = 16'h7FFF;
    we_cnt = 0; busy_cnt = 0; bad_addr = 0; bad_data = 0;
    first_we = -1; last_we = -1; exp_addr = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fill_busy) busy_cnt++;
      if (cram_we) begin
        if (cram_addr !== exp_addr) bad_addr++;
        if (cram_data !== 16'h7FFF) bad_data++;
        exp_addr = 8'(exp_addr + 8'd1);
        we_cnt++;
        if (first_we < 0) first_we = i;
        last_we = i;
      end
      if (i == 0)   begin fill_start = 1'b0; fill_data = 16'h0000; end
      if (i == 100) begin fill_start = 1'b1; fill_data = 16'h1111; end
      if (i == 101) begin fill_start = 1'b0; fill_data = 16'h0000; end
    end
    check("fill.we_count",   32'(we_cnt),   32'd256);
    check("fill.busy_count", 32'(busy_cnt), 32'd256);
    check("fill.bad_addr",   32'(bad_addr), 32'd0);
    check("fill.bad_data",   32'(bad_data), 32'd0);
    check("fill.contig",     32'(last_we - first_we), 32'd255);
    check("fill.busy_end",   32'(fill_busy), 32'h0);
    check("fill.last_addr",  32'(cram_addr), 32'hFF);

    // Blank gating of a held DMA request
    wr_blank_only = 1'b1; blank = 1'b0;
    dma_req = 1'b1; dma_addr = 8'h42; dma_data = 16'hBEEF;
    we_cnt = 0; ack_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      we_cnt  += int'(cram_we);
      ack_cnt += int'(dma_ack);
    end
    check("gate.we",  32'(we_cnt),  32'h0);
    check("gate.ack", 32'(ack_cnt), 32'h0);
    blank = 1'b1;
    @(negedge clk);
    check("gate.open_we",   32'(cram_we),   32'h1);
    check("gate.open_ack",  32'(dma_ack),   32'h1);
    check("gate.open_addr", 32'(cram_addr), 32'h42);
    check("gate.open_data", 32'(cram_data), 32'hBEEF);
    dma_req = 1'b0;
    @(negedge clk);
    check("gate.after_we", 32'(cram_we), 32'h0);
    blank = 1'b0;

    // Overflow: second post overwrites the gated slot
    cpu_byte(9'h006, 8'h11);
    cpu_byte(9'h007, 8'h11);
    cpu_byte(9'h006, 8'h22);
    cpu_byte(9'h007, 8'h22);
    @(negedge clk);
    cpu_wr = 1'b0;
    check("ovf.flag",  32'(cpu_ovf), 32'h1);
    check("ovf.gated", 32'(cram_we), 32'h0);
    blank = 1'b1;
    @(negedge clk);
    check("ovf.we",   32'(cram_we),   32'h1);
    check("ovf.addr", 32'(cram_addr), 32'h03);
    check("ovf.data", 32'(cram_data), 32'h2222);
    we_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      we_cnt += int'(cram_we);
    end
    check("ovf.single",  32'(we_cnt),  32'h0);
    check("ovf.sticky",  32'(cpu_ovf), 32'h1);
    blank = 1'b0; wr_blank_only = 1'b0;

    // Reset mid-fill at entry 80h
    @(negedge clk);
    fill_start = 1'b1; fill_data = 16'h1234;
    @(negedge clk);
    fill_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (cram_we && cram_addr == 8'h80) found = 1'b1;
      else @(negedge clk);
    end
    check("rst.reach_80", 32'(found), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst.mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we_cnt = 0; busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      we_cnt   += int'(cram_we);
      busy_cnt += int'(fill_busy);
    end
    check("rst.no_we",   32'(we_cnt),   32'h0);
    check("rst.no_busy", 32'(busy_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
